fifo_scoreboard: RTL and testbench
==================================

# fifo_scoreboard

Parametrised, synthesizable scoreboard that shadows a synchronous FIFO from its write/read handshakes and status flags. It keeps a reference queue and compares every popped word against the expected word. It reports overflow, underflow, data mismatch and full/empty flag disagreement as sticky registered flags, with a saturating error counter and first-error capture. It sits beside any FIFO instance, in simulation, formal or on-silicon debug, and replaces the per-instance hard-coded 4×4 checker.

## Interface
- DATA_W, 8: data width checked.
- DEPTH, 16: DUT FIFO capacity in words. Any value ≥2; need not be a power of two.
- READ_LAT, 0: DUT read latency. 0 means rd_data is valid in the rd_vld cycle. 1 means rd_data is valid the cycle after rd_vld.
- CNT_W, 8: error counter width.
- clk  in  1  clock; all logic on the rising edge.
- rst_b  in  1  reset, asynchronous, active-low.
- wr_vld  in  1  accepted push into the DUT.
- wr_data  in  DATA_W  pushed word.
- rd_vld  in  1  accepted pop from the DUT.
- rd_data  in  DATA_W  DUT output word, timed per READ_LAT.
- dut_full  in  1  DUT full flag.
- dut_empty  in  1  DUT empty flag.
- clr_err  in  1  synchronous clear of error state.
- occupancy  out  $clog2(DEPTH+1)  model word count.
- err_overflow  out  1  sticky.
- err_underflow  out  1  sticky.
- err_mismatch  out  1  sticky.
- err_flags  out  1  sticky; DUT flag disagreement.
- err_count  out  CNT_W  saturating count of error events.
- first_err_code  out  2  first error type: 0 overflow, 1 underflow, 2 mismatch, 3 flags.
- first_err_idx  out  16  pop index at the first error.
- exp_data  out  DATA_W  last expected word compared.

## Operation
- Model: a DEPTH-entry register array with rd_ptr and wr_ptr, each wrapping at DEPTH-1 to 0, plus an occupancy counter.
- Push: wr_vld and occupancy<DEPTH writes wr_data at wr_ptr, and wr_ptr advances.
- Simultaneous push+pop with occupancy==DEPTH is legal. Both execute and occupancy is unchanged.
- Pop: rd_vld and occupancy>0 sets expected = mem[rd_ptr], and rd_ptr advances.
- Fall-through: rd_vld and wr_vld with occupancy==0 sets expected = wr_data. The word is not stored and occupancy stays 0.
- Overflow: wr_vld, !rd_vld, occupancy==DEPTH. The push is dropped from the model and err_overflow is set.
- Underflow: rd_vld, !wr_vld, occupancy==0. There is no compare, pointers hold, and err_underflow is set.
- Compare: the expected word and a compare-valid bit pass through a READ_LAT-stage pipe and are compared against rd_data. Inequality sets err_mismatch. exp_data loads the expected word on every compare.
- Flag check runs every cycle. If dut_full != (occupancy==DEPTH) or dut_empty != (occupancy==0), err_flags is set.
- err_count adds the number of error events in the cycle (0–4) and saturates at 2^CNT_W-1.
- first_err_code and first_err_idx load only when no error is recorded yet. If several errors occur in the same cycle, the lowest code wins.
- pop_idx is an internal 16-bit counter. It increments on each pop that has a compare and wraps.
- clr_err clears all err_* outputs, err_count and the first-error record. The model state is unaffected. An error detected in the same cycle as clr_err is recorded, because set wins over clear.

## Timing
- Reset (async assert, sync-clocked release): pointers, occupancy, pop_idx, error state, exp_data and compare pipe all go to 0. Memory contents are don't-care.
- occupancy reflects the handshakes one cycle after they occur.
- Overflow, underflow and flag errors are visible one cycle after the offending cycle.
- A mismatch is visible READ_LAT+1 cycles after the rd_vld cycle.
- Reset mid-operation discards in-flight compares. No error is raised afterwards for them.
- Flag check uses the registered occupancy, compared against the current dut_full and dut_empty.

## Test plan
- DEPTH=4, READ_LAT=0: push 0x11,0x22,0x33, pop 3 with matching data -> no errors, occupancy 3→0, exp_data=0x33.
- Fill 4 words, then push 0x55 alone -> err_overflow=1, first_err_code=0, err_count=1, occupancy stays 4. Next pop expects the oldest word.
- Empty, push+pop same cycle with wr_data=0xA5 and rd_data=0xA5 -> no error, occupancy 0. Repeat with rd_data=0xA4 -> err_mismatch one cycle later.
- READ_LAT=1: push 0x01,0x02, pop 2 with rd_data lagging 1 cycle, second value 0x07 -> err_mismatch at cycle pop2+2, first_err_idx=1, exp_data=0x02.
- Pop on empty, then assert dut_full while occupancy=0 -> err_underflow and err_flags both set, err_count=2, first_err_code=1. clr_err -> all cleared.
- CNT_W=2: inject 5 mismatches -> err_count saturates at 3. Assert rst_b low mid-stream -> every output is 0 after the reset edge.

Source files
------------

// File: rtl/fifo_scoreboard.sv
// Shadow model of a synchronous FIFO: tracks pushes/pops, checks popped data and status flags,
// and records sticky errors with a saturating count and first-error capture.
module fifo_scoreboard #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned READ_LAT = 0,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       wr_vld,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_vld,
  input  logic [DATA_W-1:0]          rd_data,
  input  logic                       dut_full,
  input  logic                       dut_empty,
  input  logic                       clr_err,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       err_overflow,
  output logic                       err_underflow,
  output logic                       err_mismatch,
  output logic                       err_flags,
  output logic [CNT_W-1:0]           err_count,
  output logic [1:0]                 first_err_code,
  output logic [15:0]                first_err_idx,
  output logic [DATA_W-1:0]          exp_data
);

  localparam int unsigned OCC_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [OCC_W-1:0]  occ_q;
  logic [15:0]       pop_idx_q;

  logic full, empty, ovf_ev, udf_ev, mm_ev, flag_ev;
  logic do_pop, do_push, fall, issue_vld;
  logic [DATA_W-1:0] issue_data;
  logic              cmp_vld;
  logic [DATA_W-1:0] cmp_data;
  logic [15:0]       cmp_idx;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    full       = (occ_q == OCC_FULL);
    empty      = (occ_q == '0);
    ovf_ev     = wr_vld & ~rd_vld & full;
    udf_ev     = rd_vld & ~wr_vld & empty;
    do_pop     = rd_vld & ~empty;
    // Push+pop on an empty model bypasses storage entirely.
    fall       = rd_vld & wr_vld & empty;
    do_push    = wr_vld & ~fall & ~ovf_ev;
    issue_vld  = do_pop | fall;
    issue_data = fall ? wr_data : mem_q[rd_ptr_q];
    flag_ev    = (dut_full != full) | (dut_empty != empty);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      occ_q     <= '0;
      pop_idx_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop) occ_q <= occ_q + OCC_W'(1);
      else if (!do_push && do_pop) occ_q <= occ_q - OCC_W'(1);
      if (issue_vld) pop_idx_q <= pop_idx_q + 16'd1;
    end
  end

  // Expected word, valid and pop index travel together to line up with rd_data.
  if (READ_LAT == 0) begin : g_lat0
    assign cmp_vld  = issue_vld;
    assign cmp_data = issue_data;
    assign cmp_idx  = pop_idx_q;
  end else begin : g_pipe
    logic [READ_LAT-1:0] vld_q;
    logic [DATA_W-1:0]   data_q [READ_LAT];
    logic [15:0]         idx_q  [READ_LAT];

    always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
        vld_q <= '0;
        for (int i = 0; i < int'(READ_LAT); i++) begin
          data_q[i] <= '0;
          idx_q[i]  <= '0;
        end
      end else begin
        vld_q[0]  <= issue_vld;
        data_q[0] <= issue_data;
        idx_q[0]  <= pop_idx_q;
        for (int i = 1; i < int'(READ_LAT); i++) begin
          vld_q[i]  <= vld_q[i-1];
          data_q[i] <= data_q[i-1];
          idx_q[i]  <= idx_q[i-1];
        end
      end
    end

    assign cmp_vld  = vld_q[READ_LAT-1];
    assign cmp_data = data_q[READ_LAT-1];
    assign cmp_idx  = idx_q[READ_LAT-1];
  end

  assign mm_ev     = cmp_vld & (cmp_data != rd_data);
  assign occupancy = occ_q;

  logic [2:0]       ev_cnt;
  logic             any_ev, recorded;
  logic [CNT_W-1:0] base_cnt, cnt_next;
  logic [CNT_W+2:0] cnt_sum;
  logic [1:0]       code_new;
  logic [15:0]      idx_new;

  always_comb begin
    ev_cnt   = 3'(ovf_ev) + 3'(udf_ev) + 3'(mm_ev) + 3'(flag_ev);
    any_ev   = |ev_cnt;
    recorded = ~clr_err & (err_overflow | err_underflow | err_mismatch | err_flags);
    base_cnt = clr_err ? '0 : err_count;
    cnt_sum  = {3'b000, base_cnt} + {{CNT_W{1'b0}}, ev_cnt};
    cnt_next = (cnt_sum > {3'b000, CNT_MAX}) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    code_new = 2'd3;
    idx_new  = pop_idx_q;
    if (ovf_ev) code_new = 2'd0;
    else if (udf_ev) code_new = 2'd1;
    else if (mm_ev) begin
      code_new = 2'd2;
      idx_new  = cmp_idx;
    end
  end

  // Clear is applied first so that an event in the same cycle still lands.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      err_overflow   <= 1'b0;
      err_underflow  <= 1'b0;
      err_mismatch   <= 1'b0;
      err_flags      <= 1'b0;
      err_count      <= '0;
      first_err_code <= 2'd0;
      first_err_idx  <= '0;
      exp_data       <= '0;
    end else begin
      err_overflow  <= (err_overflow & ~clr_err) | ovf_ev;
      err_underflow <= (err_underflow & ~clr_err) | udf_ev;
      err_mismatch  <= (err_mismatch & ~clr_err) | mm_ev;
      err_flags     <= (err_flags & ~clr_err) | flag_ev;
      err_count     <= cnt_next;
      if (!recorded && any_ev) begin
        first_err_code <= code_new;
        first_err_idx  <= idx_new;
      end else if (clr_err) begin
        first_err_code <= 2'd0;
        first_err_idx  <= '0;
      end
      if (cmp_vld) exp_data <= cmp_data;
    end
  end

endmodule

// File: tb/tb_fifo_scoreboard.sv
// Two scoreboard instances (DEPTH 4/lat 0/2-bit count, DEPTH 5/lat 1) checked against a queue model,
// a directed vector table and hand-written latency, saturation and reset sequences.
module tb_fifo_scoreboard;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       wr_vld = 1'b0, rd_vld = 1'b0, clr_err = 1'b0;
  logic [7:0] wr_data = '0, rd_data0 = '0, rd_data1 = '0;
  logic       dut_full0 = 1'b0, dut_empty0 = 1'b1, dut_full1 = 1'b0, dut_empty1 = 1'b1;

  logic [2:0]  occ0, occ1;
  logic        ov0, un0, mm0, fl0, ov1, un1, mm1, fl1;
  logic [1:0]  cnt0, code0, code1;
  logic [7:0]  cnt1, exp0, exp1;
  logic [15:0] idx0, idx1;

  always #5 clk = ~clk;

  fifo_scoreboard #(.DATA_W(8), .DEPTH(4), .READ_LAT(0), .CNT_W(2)) u0 (
    .clk(clk), .rst_b(rst_b), .wr_vld(wr_vld), .wr_data(wr_data), .rd_vld(rd_vld),
    .rd_data(rd_data0), .dut_full(dut_full0), .dut_empty(dut_empty0), .clr_err(clr_err),
    .occupancy(occ0), .err_overflow(ov0), .err_underflow(un0), .err_mismatch(mm0),
    .err_flags(fl0), .err_count(cnt0), .first_err_code(code0), .first_err_idx(idx0),
    .exp_data(exp0)
  );

  fifo_scoreboard #(.DATA_W(8), .DEPTH(5), .READ_LAT(1), .CNT_W(8)) u1 (
    .clk(clk), .rst_b(rst_b), .wr_vld(wr_vld), .wr_data(wr_data), .rd_vld(rd_vld),
    .rd_data(rd_data1), .dut_full(dut_full1), .dut_empty(dut_empty1), .clr_err(clr_err),
    .occupancy(occ1), .err_overflow(ov1), .err_underflow(un1), .err_mismatch(mm1),
    .err_flags(fl1), .err_count(cnt1), .first_err_code(code1), .first_err_idx(idx1),
    .exp_data(exp1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain queues plus error bookkeeping, one slot per instance.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         m_ov[2], m_un[2], m_mm[2], m_fl[2];
  int         m_cnt[2], m_code[2], m_idx[2], m_pop[2];
  logic [7:0] m_exp[2];
  bit         pv;
  logic [7:0] pe;
  int         pi;

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [7:0] qfront(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin
      m_ov[k] = 0; m_un[k] = 0; m_mm[k] = 0; m_fl[k] = 0;
      m_cnt[k] = 0; m_code[k] = 0; m_idx[k] = 0; m_pop[k] = 0; m_exp[k] = '0;
    end
    pv = 0; pe = '0; pi = 0;
  endtask

  // Word that a correct DUT would present on rd_data this cycle.
  function automatic logic [7:0] good_rd(input int k, input bit w, input logic [7:0] wd,
                                         input bit r);
    if (k == 1) return pe;
    if (r && qsize(0) > 0) return qfront(0);
    if (r && w) return wd;
    return 8'h00;
  endfunction

  task automatic model_step(input int k, input bit w, input logic [7:0] wd, input bit r,
                            input logic [7:0] rdv, input bit df, input bit de, input bit c);
    int d    = (k == 0) ? 4 : 5;
    int maxc = (k == 0) ? 3 : 255;
    int occ  = qsize(k);
    bit ov, un, fl, mm, iv, cv;
    logic [7:0] ie, ce;
    int iidx, ci, n;
    ov = w && !r && occ == d;
    un = r && !w && occ == 0;
    fl = (df != (occ == d)) || (de != (occ == 0));
    iv = 0;
    ie = '0;
    if (r && occ > 0) begin
      ie = qfront(k);
      if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      iv = 1;
    end else if (r && w) begin
      ie = wd;
      iv = 1;
    end
    if (w && !(r && occ == 0) && !ov) begin
      if (k == 0) q0.push_back(wd); else q1.push_back(wd);
    end
    iidx = m_pop[k];
    if (iv) m_pop[k] = (m_pop[k] + 1) % 65536;
    if (k == 0) begin
      cv = iv; ce = ie; ci = iidx;
    end else begin
      cv = pv; ce = pe; ci = pi;
      pv = iv; pe = ie; pi = iidx;
    end
    mm = cv && (ce != rdv);
    if (cv) m_exp[k] = ce;
    if (c) begin
      m_ov[k] = 0; m_un[k] = 0; m_mm[k] = 0; m_fl[k] = 0;
      m_cnt[k] = 0; m_code[k] = 0; m_idx[k] = 0;
    end
    n = int'(ov) + int'(un) + int'(mm) + int'(fl);
    if (!(m_ov[k] || m_un[k] || m_mm[k] || m_fl[k]) && n > 0) begin
      m_code[k] = ov ? 0 : un ? 1 : mm ? 2 : 3;
      m_idx[k]  = (m_code[k] == 2) ? ci : iidx;
    end
    m_ov[k] |= ov; m_un[k] |= un; m_mm[k] |= mm; m_fl[k] |= fl;
    m_cnt[k] = (m_cnt[k] + n > maxc) ? maxc : m_cnt[k] + n;
  endtask

  task automatic chk(input string name, input int k, input longint act, input longint want);
    checks++;
    if (act != want) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s u%0d: got 0x%0h, expected 0x%0h at %0t", name, k, act, want, $time);
    end
  endtask

  task automatic check_model(input int k);
    if (k == 0) begin
      chk("occupancy", 0, occ0, qsize(0));
      chk("err_bits", 0, {ov0, un0, mm0, fl0}, {m_ov[0], m_un[0], m_mm[0], m_fl[0]});
      chk("err_count", 0, cnt0, m_cnt[0]);
      chk("first_err", 0, {code0, idx0}, {m_code[0][1:0], m_idx[0][15:0]});
      chk("exp_data", 0, exp0, m_exp[0]);
    end else begin
      chk("occupancy", 1, occ1, qsize(1));
      chk("err_bits", 1, {ov1, un1, mm1, fl1}, {m_ov[1], m_un[1], m_mm[1], m_fl[1]});
      chk("err_count", 1, cnt1, m_cnt[1]);
      chk("first_err", 1, {code1, idx1}, {m_code[1][1:0], m_idx[1][15:0]});
      chk("exp_data", 1, exp1, m_exp[1]);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_u0"}, 0, {occ0, ov0, un0, mm0, fl0, cnt0, code0, idx0, exp0}, 0);
    chk({tag, "_u1"}, 1, {occ1, ov1, un1, mm1, fl1, cnt1, code1, idx1, exp1}, 0);
  endtask

  // One clock of stimulus; x0/x1 corrupt the correct rd_data, f0/f1 invert dut_full.
  task automatic step(input bit w, input logic [7:0] wd, input bit r, input logic [7:0] x0,
                      input logic [7:0] x1, input bit f0, input bit f1, input bit c);
    wr_vld = w; wr_data = wd; rd_vld = r; clr_err = c;
    rd_data0   = good_rd(0, w, wd, r) ^ x0;
    rd_data1   = good_rd(1, w, wd, r) ^ x1;
    dut_full0  = (qsize(0) == 4) ^ f0;
    dut_empty0 = (qsize(0) == 0);
    dut_full1  = (qsize(1) == 5) ^ f1;
    dut_empty1 = (qsize(1) == 0);
    model_step(0, w, wd, r, rd_data0, dut_full0, dut_empty0, c);
    model_step(1, w, wd, r, rd_data1, dut_full1, dut_empty1, c);
    @(posedge clk);
    #1;
    check_model(0);
    check_model(1);
  endtask

  task automatic do_reset();
    wr_vld = 0; rd_vld = 0; clr_err = 0;
    rst_b = 0;
    model_reset();
    @(posedge clk);
    #1;
    check_zero("reset");
    rst_b = 1;
  endtask

  typedef struct {
    bit         w;
    logic [7:0] wd;
    bit         r;
    logic [7:0] rdx;
    bit         flip;
    bit         clr;
    int         occ;
    logic [3:0] err;
    int         cnt;
    int         code;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [22];

  initial begin
    // u0 expectations: occupancy, {ovf,udf,mm,flags}, count, first code, exp_data
    tbl[0]  = '{1, 8'h11, 0, 8'h00, 0, 0, 1, 4'b0000, 0, 0, 8'h00};
    tbl[1]  = '{1, 8'h22, 0, 8'h00, 0, 0, 2, 4'b0000, 0, 0, 8'h00};
    tbl[2]  = '{1, 8'h33, 0, 8'h00, 0, 0, 3, 4'b0000, 0, 0, 8'h00};
    tbl[3]  = '{0, 8'h00, 1, 8'h00, 0, 0, 2, 4'b0000, 0, 0, 8'h11};
    tbl[4]  = '{0, 8'h00, 1, 8'h00, 0, 0, 1, 4'b0000, 0, 0, 8'h22};
    tbl[5]  = '{0, 8'h00, 1, 8'h00, 0, 0, 0, 4'b0000, 0, 0, 8'h33};
    tbl[6]  = '{1, 8'h41, 0, 8'h00, 0, 0, 1, 4'b0000, 0, 0, 8'h33};
    tbl[7]  = '{1, 8'h42, 0, 8'h00, 0, 0, 2, 4'b0000, 0, 0, 8'h33};
    tbl[8]  = '{1, 8'h43, 0, 8'h00, 0, 0, 3, 4'b0000, 0, 0, 8'h33};
    tbl[9]  = '{1, 8'h44, 0, 8'h00, 0, 0, 4, 4'b0000, 0, 0, 8'h33};
    tbl[10] = '{1, 8'h55, 0, 8'h00, 0, 0, 4, 4'b1000, 1, 0, 8'h33};
    tbl[11] = '{0, 8'h00, 1, 8'h00, 0, 0, 3, 4'b1000, 1, 0, 8'h41};
    tbl[12] = '{0, 8'h00, 0, 8'h00, 0, 1, 3, 4'b0000, 0, 0, 8'h41};
    tbl[13] = '{0, 8'h00, 1, 8'h00, 0, 0, 2, 4'b0000, 0, 0, 8'h42};
    tbl[14] = '{0, 8'h00, 1, 8'h00, 0, 0, 1, 4'b0000, 0, 0, 8'h43};
    tbl[15] = '{0, 8'h00, 1, 8'h00, 0, 0, 0, 4'b0000, 0, 0, 8'h44};
    tbl[16] = '{1, 8'hA5, 1, 8'h00, 0, 0, 0, 4'b0000, 0, 0, 8'hA5};
    tbl[17] = '{1, 8'hA5, 1, 8'h01, 0, 0, 0, 4'b0010, 1, 2, 8'hA5};
    tbl[18] = '{0, 8'h00, 0, 8'h00, 0, 1, 0, 4'b0000, 0, 0, 8'hA5};
    tbl[19] = '{0, 8'h00, 1, 8'h00, 0, 0, 0, 4'b0100, 1, 1, 8'hA5};
    tbl[20] = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 4'b0101, 2, 1, 8'hA5};
    tbl[21] = '{0, 8'h00, 0, 8'h00, 0, 1, 0, 4'b0000, 0, 0, 8'hA5};

    model_reset();
    @(posedge clk);
    #1;
    check_zero("reset");
    rst_b = 1;

    foreach (tbl[i]) begin
      step(tbl[i].w, tbl[i].wd, tbl[i].r, tbl[i].rdx, 8'h00, tbl[i].flip, 1'b0, tbl[i].clr);
      chk($sformatf("vec%0d_occ", i), 0, occ0, tbl[i].occ);
      chk($sformatf("vec%0d_err", i), 0, {ov0, un0, mm0, fl0}, tbl[i].err);
      chk($sformatf("vec%0d_cnt", i), 0, cnt0, tbl[i].cnt);
      chk($sformatf("vec%0d_code", i), 0, code0, tbl[i].code);
      chk($sformatf("vec%0d_exp", i), 0, exp0, tbl[i].exp);
    end

    // Latency-1 instance: second popped word returns as 0x07 instead of 0x02.
    do_reset();
    step(1, 8'h01, 0, 8'h00, 8'h00, 0, 0, 0);
    step(1, 8'h02, 0, 8'h00, 8'h00, 0, 0, 0);
    step(0, 8'h00, 1, 8'h00, 8'h00, 0, 0, 0);
    step(0, 8'h00, 1, 8'h00, 8'h00, 0, 0, 0);
    chk("lat1_no_early_mm", 1, mm1, 0);
    step(0, 8'h00, 0, 8'h00, 8'h05, 0, 0, 0);
    chk("lat1_mm", 1, mm1, 1);
    chk("lat1_idx", 1, idx1, 1);
    chk("lat1_exp", 1, exp1, 8'h02);
    chk("lat1_code", 1, code1, 2);

    // Five fall-through mismatches saturate the 2-bit counter.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 8'(8'h30 + i), 1, 8'hFF, 8'h00, 0, 0, 0);
    chk("sat_cnt", 0, cnt0, 3);
    chk("sat_mm", 0, mm0, 1);

    // Reset while a latency-1 compare is still in flight.
    step(1, 8'h77, 1, 8'hFF, 8'h00, 0, 0, 0);
    wr_vld = 0; rd_vld = 0; clr_err = 0;
    rst_b = 0;
    model_reset();
    #1;
    check_zero("async_rst");
    @(posedge clk);
    #1;
    check_zero("rst_edge");
    rst_b = 1;
    step(0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0);
    chk("no_stale_mm", 1, mm1, 0);

    for (int i = 0; i < 3000; i++) begin
      bit w, r, c, f0, f1;
      logic [7:0] x0, x1;
      w  = ($urandom_range(0, 99) < 55);
      r  = ($urandom_range(0, 99) < 50);
      c  = ($urandom_range(0, 63) == 0);
      f0 = ($urandom_range(0, 49) == 0);
      f1 = ($urandom_range(0, 49) == 0);
      x0 = ($urandom_range(0, 39) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      x1 = ($urandom_range(0, 39) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      step(w, 8'($urandom), r, x0, x1, f0, f1, c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
